addsub_stream_core: RTL

Parametrised two-stream add/subtract compute engine: joins two AXI-Stream sample inputs (a, b) beat-by-beat and emits a+b and a−b on two independent AXI-Stream outputs.
- Generalises the fixed 32-bit HLS add/sub core: configurable component width, real or complex samples, runtime wrap/saturate mode, per-output buffering so one stalled output does not stall the other until its buffer fills.
- Sits between the per-port CHDR deframers and framers inside an RFNoC block, in the compute-engine clock domain.

---
 rtl/addsub_pkg.sv | 45 ++++
 rtl/addsub_out_fifo.sv | 105 ++++++++++
 rtl/addsub_stream_core.sv | 124 ++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared helpers for the add/sub stream core: derived width helpers,
// error-counter width, and the wrap/saturate narrowing function.
`timescale 1ns/1ps
package addsub_pkg;

  // Width of the tlast-mismatch counter.
  localparam int ERR_CNT_W = 16;

  // Number of components per beat.
  function automatic int calc_nc(input int complex_en);
    return complex_en + 1;
  endfunction

  // Total beat data width.
  function automatic int calc_dw(input int width, input int complex_en);
    return width * (complex_en + 1);
  endfunction

  // Narrow a (w+1)-bit two's complement result to w bits.
  // The value sits in the low w+1 bits of v. With sat=0 the low w bits are
  // kept as-is; with sat=1 an overflow (top two bits differ) clamps to the
  // most negative or most positive w-bit value. Bits above w in the return
  // value are don't-care; callers keep only the low w bits.
  function automatic logic [31:0] sat_wrap(input logic [32:0] v,
                                           input int w,
                                           input logic sat);
    logic [32:0] top_bit;
    logic [32:0] sgn_bit;
    logic [31:0] min_val;
    logic [31:0] res;
    logic        top;
    logic        sgn;
    top_bit = 33'd1 << w;
    sgn_bit = 33'd1 << (w - 1);
    top     = |(v & top_bit);
    sgn     = |(v & sgn_bit);
    min_val = 32'd1 << (w - 1);
    res     = v[31:0];
    if (sat && (top != sgn)) begin
      res = top ? min_val : (min_val - 32'd1);
    end
    return res;
  endfunction

endpackage

// File: rtl/addsub_out_fifo.sv
// Output FIFO for one result stream. Total capacity is 2^DEPTH_LOG2 beats:
// one registered head (drives the output directly) plus a small memory
// behind it. The head keeps its last value when the FIFO goes empty.
`timescale 1ns/1ps
module addsub_out_fifo import addsub_pkg::*; #(
  parameter int DW_E       = 33,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic            ap_clk,
  input  logic            ap_rst_n,
  input  logic            wr_en,
  input  logic [DW_E-1:0] wr_data,
  output logic            full,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [DW_E-1:0] rd_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DW_E-1:0]       mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   mem_cnt_q, mem_cnt_d;
  logic                  head_valid_q, head_valid_d;
  logic [DW_E-1:0]       head_data_q, head_data_d;
  logic                  push;
  logic                  pop;
  logic                  head_free;
  logic                  mem_we;
  logic                  mem_rd;

  // Full counts the head slot plus memory entries; it is a registered view,
  // so a read in the same cycle does not open room for a write.
  assign full     = (mem_cnt_q + {{DEPTH_LOG2{1'b0}}, head_valid_q})
                    == (DEPTH_LOG2 + 1)'(DEPTH);
  assign rd_valid = head_valid_q;
  assign rd_data  = head_data_q;
  assign push     = wr_en & ~full;
  assign pop      = head_valid_q & rd_ready;
  assign head_free = ~head_valid_q | pop;

  // Refill the head from memory (oldest first), bypass straight to the head
  // when memory is empty, otherwise queue the new beat in memory.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    mem_cnt_d    = mem_cnt_q;
    head_valid_d = head_valid_q;
    head_data_d  = head_data_q;
    mem_we       = 1'b0;
    mem_rd       = 1'b0;
    if (head_free) begin
      if (mem_cnt_q != '0) begin
        head_valid_d = 1'b1;
        head_data_d  = mem_q[rd_ptr_q];
        mem_rd       = 1'b1;
        mem_we       = push;
      end else if (push) begin
        head_valid_d = 1'b1;
        head_data_d  = wr_data;
      end else begin
        head_valid_d = 1'b0;
      end
    end else begin
      mem_we = push;
    end
    if (mem_we) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (mem_rd) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (mem_we && !mem_rd) begin
      mem_cnt_d = mem_cnt_q + 1'b1;
    end else if (!mem_we && mem_rd) begin
      mem_cnt_d = mem_cnt_q - 1'b1;
    end
  end

  // Pointer, count and head registers; reset empties the FIFO at once.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mem_cnt_q    <= '0;
      head_valid_q <= 1'b0;
      head_data_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_cnt_q    <= mem_cnt_d;
      head_valid_q <= head_valid_d;
      head_data_q  <= head_data_d;
    end
  end

  // Storage array; contents need no reset since the count gates reads.
  always_ff @(posedge ap_clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/addsub_stream_core.sv
// Two-stream add/subtract engine: joins streams A and B beat-by-beat and
// writes A+B and A-B into independent output FIFOs.
// Optional macro ADDSUB_TLAST_CHK_EN adds the err_cnt port counting beats
// whose a_tlast and b_tlast disagree.
`timescale 1ns/1ps
module addsub_stream_core import addsub_pkg::*; #(
  parameter  int WIDTH           = 16,
  parameter  int COMPLEX         = 1,
  parameter  int FIFO_DEPTH_LOG2 = 2,
  localparam int NC              = calc_nc(COMPLEX),
  localparam int DW              = calc_dw(WIDTH, COMPLEX)
) (
  input  logic          ap_clk,
  input  logic          ap_rst_n,
  input  logic          mode_sat,
  input  logic [DW-1:0] a_tdata,
  input  logic          a_tvalid,
  output logic          a_tready,
  input  logic          a_tlast,
  input  logic [DW-1:0] b_tdata,
  input  logic          b_tvalid,
  output logic          b_tready,
  input  logic          b_tlast,
  output logic [DW-1:0] add_tdata,
  output logic          add_tvalid,
  input  logic          add_tready,
  output logic          add_tlast,
  output logic [DW-1:0] sub_tdata,
  output logic          sub_tvalid,
  input  logic          sub_tready,
  output logic          sub_tlast
`ifdef ADDSUB_TLAST_CHK_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  logic          add_full;
  logic          sub_full;
  logic          fire;
  logic [DW-1:0] add_res;
  logic [DW-1:0] sub_res;
  logic [DW:0]   add_out;
  logic [DW:0]   sub_out;

  // Both inputs move together only when both results have room.
  assign fire     = a_tvalid & b_tvalid & ~add_full & ~sub_full;
  assign a_tready = fire;
  assign b_tready = fire;

  // Per-component arithmetic at WIDTH+1 bits; no carry crosses components.
  for (genvar gi = 0; gi < NC; gi++) begin : g_comp
    logic [WIDTH-1:0] a_c;
    logic [WIDTH-1:0] b_c;
    logic [WIDTH:0]   sum_x;
    logic [WIDTH:0]   dif_x;
    assign a_c   = a_tdata[gi*WIDTH +: WIDTH];
    assign b_c   = b_tdata[gi*WIDTH +: WIDTH];
    assign sum_x = {a_c[WIDTH-1], a_c} + {b_c[WIDTH-1], b_c};
    assign dif_x = {a_c[WIDTH-1], a_c} - {b_c[WIDTH-1], b_c};
    assign add_res[gi*WIDTH +: WIDTH] = WIDTH'(sat_wrap(33'(sum_x), WIDTH, mode_sat));
    assign sub_res[gi*WIDTH +: WIDTH] = WIDTH'(sat_wrap(33'(dif_x), WIDTH, mode_sat));
  end

  addsub_out_fifo #(
    .DW_E       (DW + 1),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_add_fifo (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .wr_en    (fire),
    .wr_data  ({a_tlast, add_res}),
    .full     (add_full),
    .rd_valid (add_tvalid),
    .rd_ready (add_tready),
    .rd_data  (add_out)
  );

  addsub_out_fifo #(
    .DW_E       (DW + 1),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_sub_fifo (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .wr_en    (fire),
    .wr_data  ({a_tlast, sub_res}),
    .full     (sub_full),
    .rd_valid (sub_tvalid),
    .rd_ready (sub_tready),
    .rd_data  (sub_out)
  );

  assign add_tdata = add_out[DW-1:0];
  assign add_tlast = add_out[DW];
  assign sub_tdata = sub_out[DW-1:0];
  assign sub_tlast = sub_out[DW];

`ifdef ADDSUB_TLAST_CHK_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Count fired beats with disagreeing tlast, holding at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (fire && (a_tlast != b_tlast) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // Mismatch counter register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_b_tlast;
  assign unused_b_tlast = b_tlast;
`endif

endmodule
